// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and defaults for the program loader.
//   state_e     - loader FSM state, fixed encodings IDLE=0 LOAD=1 READY=2 RUN=3
//   DEF_DATA_W  - default instruction word width
//   DEF_ADDR_W  - default program address width (depth = 2**ADDR_W)
package prog_loader_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: load/fetch bus of the program loader.
//   master modport - drives load words, start request and CPU fetches
//   slave modport  - the loader; returns fetched words and status
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
);

  logic [DATA_W-1:0] prog_data_in;
  logic [ADDR_W-1:0] prog_addr;
  logic              prog_write_enable;
  logic              start_execution;
  logic              fetch_valid;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] instr_out;
  logic              instr_valid;
  logic              load_done;
  logic              running;
  logic [ADDR_W:0]   prog_length;
  logic              load_error;
  logic [DATA_W-1:0] checksum;

  modport master (
    output prog_data_in, prog_addr, prog_write_enable, start_execution,
           fetch_valid, fetch_addr,
    input  instr_out, instr_valid, load_done, running, prog_length,
           load_error, checksum
  );

  modport slave (
    input  prog_data_in, prog_addr, prog_write_enable, start_execution,
           fetch_valid, fetch_addr,
    output instr_out, instr_valid, load_done, running, prog_length,
           load_error, checksum
  );

endinterface

// File: rtl/prog_mem.sv
// prog_mem: DATA_W x 2**ADDR_W program store, one write port and one
// synchronous read port. rd_data holds its value while rd_en is low.
//   clock            - rising-edge clock
//   wr_en/addr/data  - write port
//   rd_en/addr       - read request; rd_data valid the next cycle
module prog_mem #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Storage array and read register; no reset, contents qualified by valid bits upstream
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/prog_loader.sv
// prog_loader: loads a program into prog_mem, then serves CPU fetches.
//   clock, reset - rising-edge clock, synchronous active-high reset
//   bus          - prog_loader_if.slave: load port, start request, fetch port,
//                  instr_out/instr_valid, load_done, running, prog_length,
//                  load_error, checksum
// Build option: define PROG_LOADER_CHECKSUM_EN to keep a running XOR of all
// accepted load words on checksum; otherwise checksum is tied to zero.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input logic         clock,
  input logic         reset,
  prog_loader_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned LEN_W = ADDR_W + 1;

  state_e             state_q, state_d;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [LEN_W-1:0]   prog_length_q, prog_length_d;
  logic               load_error_q, load_error_d;
  logic               load_done_q, load_done_d;
  logic               running_q, running_d;
  logic               instr_valid_q, instr_valid_d;
  logic               fetch_hit_q, fetch_hit_d;
  logic               wr_accept;
  logic               rd_en;
  logic [LEN_W-1:0]   addr_len;
  logic [DATA_W-1:0]  rd_data;

  // Next state, bookkeeping and fetch control
  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    prog_length_d = prog_length_q;
    load_error_d  = load_error_q;
    fetch_hit_d   = fetch_hit_q;
    instr_valid_d = 1'b0;
    rd_en         = 1'b0;
    wr_accept     = 1'b0;
    addr_len      = LEN_W'(bus.prog_addr) + LEN_W'(1);

    unique case (state_q)
      ST_IDLE:  if (bus.prog_write_enable) state_d = ST_LOAD;
      ST_LOAD:  if (!bus.prog_write_enable) state_d = ST_READY;
      // A write request beats a simultaneous start request
      ST_READY: begin
        if (bus.prog_write_enable)    state_d = ST_LOAD;
        else if (bus.start_execution) state_d = ST_RUN;
      end
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase

    wr_accept = bus.prog_write_enable && (state_q != ST_RUN);
    if (wr_accept) begin
      valid_d[bus.prog_addr] = 1'b1;
      if (addr_len > prog_length_q) prog_length_d = addr_len;
    end
    if (bus.prog_write_enable && (state_q == ST_RUN)) load_error_d = 1'b1;

    // Fetch hit flag masks never-written entries to a zero NOP
    if ((state_q == ST_RUN) && bus.fetch_valid) begin
      rd_en         = 1'b1;
      instr_valid_d = 1'b1;
      fetch_hit_d   = valid_q[bus.fetch_addr];
    end

    load_done_d = (state_d == ST_READY);
    running_d   = (state_d == ST_RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      valid_q       <= '0;
      prog_length_q <= '0;
      load_error_q  <= 1'b0;
      load_done_q   <= 1'b0;
      running_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      fetch_hit_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      prog_length_q <= prog_length_d;
      load_error_q  <= load_error_d;
      load_done_q   <= load_done_d;
      running_q     <= running_d;
      instr_valid_q <= instr_valid_d;
      fetch_hit_q   <= fetch_hit_d;
    end
  end

  prog_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clock   (clock),
    .wr_en   (wr_accept && !reset),
    .wr_addr (bus.prog_addr),
    .wr_data (bus.prog_data_in),
    .rd_en   (rd_en && !reset),
    .rd_addr (bus.fetch_addr),
    .rd_data (rd_data)
  );

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;

  // Running XOR of every accepted load word, duplicates included
  always_comb begin
    checksum_d = checksum_q;
    if (wr_accept) checksum_d = checksum_q ^ bus.prog_data_in;
  end

  always_ff @(posedge clock) begin
    if (reset) checksum_q <= '0;
    else       checksum_q <= checksum_d;
  end

  assign bus.checksum = checksum_q;
`else
  assign bus.checksum = '0;
`endif

  assign bus.instr_out   = fetch_hit_q ? rd_data : '0;
  assign bus.instr_valid = instr_valid_q;
  assign bus.load_done   = load_done_q;
  assign bus.running     = running_q;
  assign bus.prog_length = prog_length_q;
  assign bus.load_error  = load_error_q;

endmodule
